// File: rtl/pb_conditioner.sv
// Conditions the two raw sequence-select pushbuttons into debounced levels and one-cycle
// step pulses, with optional auto-repeat and a lockout so up and down never pulse together.
module pb_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic pb_up_raw,
  input  logic pb_dn_raw,
  output logic pb_seq_up,
  output logic pb_seq_dn,
  output logic pb_up_level,
  output logic pb_dn_level
);

  localparam int unsigned MaxDh     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxDh > REPEAT_CYCLES) ? MaxDh : REPEAT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] DebTerm  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldTerm = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RptTerm  = CntW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRpt} state_e;

  // Channel 0 is the up key, channel 1 the down key.
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;

  assign raw = {pb_dn_raw, pb_up_raw};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic            sync1_q;
    logic            sync2_q;
    logic            s_q;
    logic            level_q;
    logic            pulse_q;
    logic            fire;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] rcnt_q;
    logic [CntW-1:0] rcnt_d;
    state_e          state_q;
    state_e          state_d;

    always_ff @(posedge CLK_50) begin
      if (reset) begin
        sync1_q <= ACTIVE_LOW;
        sync2_q <= ACTIVE_LOW;
        s_q     <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        state_q <= StIdle;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= raw[i];
        sync2_q <= sync1_q;
        s_q     <= sync2_q ^ ACTIVE_LOW;
        // Any sample matching the accepted level throws away the accumulated count.
        if (s_q != level_q) begin
          if (cnt_q == DebTerm) begin
            level_q <= s_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        // Suppressed pulses are dropped; the FSM has already moved on.
        pulse_q <= fire & ~level[1-i];
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire    = 1'b0;
      case (state_q)
        StIdle: begin
          if (level_q) begin
            state_d = StHeld;
            rcnt_d  = '0;
            fire    = 1'b1;
          end
        end
        StHeld: begin
          if (!level_q) begin
            state_d = StIdle;
          end else if (REPEAT_EN) begin
            if (rcnt_q == HoldTerm) begin
              state_d = StRpt;
              rcnt_d  = '0;
              fire    = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        StRpt: begin
          if (!level_q) begin
            state_d = StIdle;
          end else if (rcnt_q == RptTerm) begin
            rcnt_d = '0;
            fire   = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    assign level[i] = level_q;
    assign pulse[i] = pulse_q;
  end

  assign pb_seq_up   = pulse[0];
  assign pb_seq_dn   = pulse[1];
  assign pb_up_level = level[0];
  assign pb_dn_level = level[1];

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus random key activity, checked against a
// behavioural model built from press age and a sliding debounce window.
module tb_pb_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset;
  logic up_raw;
  logic dn_raw;
  logic a_up, a_dn, a_ul, a_dl;
  logic b_up, b_dn, b_ul, b_dl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pb_conditioner #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .CLK_50(clk), .reset(reset), .pb_up_raw(up_raw), .pb_dn_raw(dn_raw),
    .pb_seq_up(a_up), .pb_seq_dn(a_dn), .pb_up_level(a_ul), .pb_dn_level(a_dl)
  );

  pb_conditioner #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) u_dut_norpt (
    .CLK_50(clk), .reset(reset), .pb_up_raw(up_raw), .pb_dn_raw(dn_raw),
    .pb_seq_up(b_up), .pb_seq_dn(b_dn), .pb_up_level(b_ul), .pb_dn_level(b_dl)
  );

  // Reference model. Index [inst]: 0 = repeat enabled, 1 = repeat disabled. Bit [c]: 0 up, 1 dn.
  localparam bit [1:0] RepEn = 2'b01;
  bit [1:0] p0, p1, p2, m_s, m_lvl, m_old;
  bit       win [2][$];
  int       age [2][2];
  bit [1:0] m_pulse [2];
  bit       m_fire;
  int       m_same;

  always @(posedge clk) begin
    if (reset) begin
      p0 = '0; p1 = '0; p2 = '0; m_lvl = '0;
      for (int c = 0; c < 2; c++) begin
        win[c].delete();
        for (int n = 0; n < 2; n++) age[n][c] = -1;
      end
      m_pulse[0] = '0;
      m_pulse[1] = '0;
    end else begin
      m_old = m_lvl;
      m_s   = p2;
      p2    = p1;
      p1    = p0;
      p0    = ~{dn_raw, up_raw};
      // Level flips once the last D samples all disagree with it.
      for (int c = 0; c < 2; c++) begin
        win[c].push_back(m_s[c]);
        if (win[c].size() > D) void'(win[c].pop_front());
        m_same = 0;
        for (int j = 0; j < win[c].size(); j++) if (win[c][j] == m_old[c]) m_same++;
        if (win[c].size() == D && m_same == 0) m_lvl[c] = ~m_old[c];
      end
      for (int n = 0; n < 2; n++) begin
        for (int c = 0; c < 2; c++) begin
          m_fire = 1'b0;
          if (!m_old[c]) begin
            age[n][c] = -1;
          end else if (age[n][c] < 0) begin
            age[n][c] = 0;
            m_fire    = 1'b1;
          end else begin
            age[n][c]++;
            if (RepEn[n] && age[n][c] >= H && (age[n][c] - H) % R == 0) m_fire = 1'b1;
          end
          m_pulse[n][c] = m_fire && !m_old[1-c];
        end
      end
    end
  end

  wire [3:0] obs_a = {a_up, a_dn, a_ul, a_dl};
  wire [3:0] obs_b = {b_up, b_dn, b_ul, b_dl};
  wire [3:0] exp_a = {m_pulse[0][0], m_pulse[0][1], m_lvl[0], m_lvl[1]};
  wire [3:0] exp_b = {m_pulse[1][0], m_pulse[1][1], m_lvl[0], m_lvl[1]};

  task automatic settle();
    up_raw = 1'b1;
    dn_raw = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    up_raw = 1'b1;
    dn_raw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({obs_a, obs_b} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs got %b required 00000000", {obs_a, obs_b});
      end
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if ({obs_a, obs_b} !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_after_reset got %b required 00000000", {obs_a, obs_b});
      end
    end
  endtask

  task automatic test_single_press();
    up_raw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 9) up_raw = 1'b1;
      n_checks++;
      if (a_up !== (k == 7)) begin
        n_fail++;
        $display("FAIL single_press_pulse edge %0d got %b required %b", k, a_up, (k == 7));
      end
      if (k <= 20) begin
        n_checks++;
        if (a_ul !== (k >= 6 && k < 16)) begin
          n_fail++;
          $display("FAIL single_press_level edge %0d got %b required %b", k, a_ul,
                   (k >= 6 && k < 16));
        end
      end
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++;
        $display("FAIL single_press_model edge %0d got %b required %b", k, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_bounce();
    int run;
    bit v;
    dn_raw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      dn_raw = (k < 39) ? 1'(((k + 1) / 2) % 2) : 1'b1;
      n_checks++;
      if ({a_dn, a_dl} !== 2'b00) begin
        n_fail++;
        $display("FAIL bounce_dn edge %0d got %b required 00", k, {a_dn, a_dl});
      end
    end
    // Random chatter with every run shorter than the debounce window.
    v   = 1'b0;
    run = $urandom_range(1, D - 1);
    dn_raw = v;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (--run == 0) begin
        v      = ~v;
        dn_raw = v;
        run    = $urandom_range(1, D - 1);
      end
      n_checks++;
      if ({a_dn, a_dl} !== 2'b00 || obs_a !== exp_a) begin
        n_fail++;
        $display("FAIL bounce_random cycle %0d got %b required %b", k, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_auto_repeat();
    up_raw = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 59) up_raw = 1'b1;
      if (k <= 56) begin
        n_checks++;
        if (a_up !== (k inside {7, 27, 35, 43, 51})) begin
          n_fail++;
          $display("FAIL repeat_pulse edge %0d got %b required %b", k, a_up,
                   (k inside {7, 27, 35, 43, 51}));
        end
      end
      n_checks++;
      if (a_dn !== 1'b0 || obs_a !== exp_a) begin
        n_fail++;
        $display("FAIL repeat_model edge %0d got %b required %b", k, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_lockout();
    up_raw = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 4) dn_raw = 1'b0;
      if (k == 39) up_raw = 1'b1;
      if (k == 69) dn_raw = 1'b1;
      if (k == 7) begin
        n_checks++;
        if (a_up !== 1'b1) begin
          n_fail++;
          $display("FAIL lockout_first_press got %b required 1", a_up);
        end
      end
      if (k >= 11 && k <= 46) begin
        n_checks++;
        if ({a_up, a_dn} !== 2'b00) begin
          n_fail++;
          $display("FAIL lockout_both_held edge %0d got %b required 00", k, {a_up, a_dn});
        end
      end
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++;
        $display("FAIL lockout_model edge %0d got %b required %b", k, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    up_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({obs_a, obs_b} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid_outputs got %b required 00000000", {obs_a, obs_b});
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k < 26) begin
        n_checks++;
        if (a_up !== (k == 7)) begin
          n_fail++;
          $display("FAIL reset_mid_pulse edge %0d got %b required %b", k, a_up, (k == 7));
        end
      end
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++;
        $display("FAIL reset_mid_model edge %0d got %b required %b", k, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_no_repeat();
    int pulses = 0;
    up_raw = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (k == 99) up_raw = 1'b1;
      if (b_up === 1'b1) pulses++;
      n_checks++;
      if (b_up !== (k == 7) || obs_b !== exp_b) begin
        n_fail++;
        $display("FAIL no_repeat edge %0d got %b required %b", k, obs_b, exp_b);
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL no_repeat_count got %0d required 1", pulses);
    end
  endtask

  task automatic test_random();
    int run_up = 1;
    int run_dn = 1;
    for (int k = 0; k < 2000; k++) begin
      if (--run_up == 0) begin
        up_raw = ~up_raw;
        run_up = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 60);
      end
      if (--run_dn == 0) begin
        dn_raw = ~dn_raw;
        run_dn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 60);
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_checks++;
      if (obs_a !== exp_a || obs_b !== exp_b || (a_up & a_dn) !== 1'b0) begin
        n_fail++;
        $display("FAIL random cycle %0d got %b/%b required %b/%b", k, obs_a, obs_b, exp_a, exp_b);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    up_raw = 1'b1;
    dn_raw = 1'b1;
    test_reset();
    test_single_press();
    settle();
    test_bounce();
    settle();
    test_auto_repeat();
    settle();
    test_lockout();
    settle();
    test_reset_mid();
    settle();
    test_no_repeat();
    settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
